// File: rtl/count_frame_sender.sv
// Steps the count mux select through every channel, captures each count byte
// and sends the set to the host as one 8N1 UART frame, LSB first.
// Optional FRAME_HEADER_EN prepends a 8'hA5 sync byte to every frame.
module count_frame_sender #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CH       = 9,
    parameter int SEL_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       send_data,
    output logic [SEL_W-1:0] sel,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, SELECT, START, DATA, STOP, FINISH} state_t;

    state_t           state, state_next;
    logic [TW-1:0]    timer;
    logic [2:0]       bit_idx;
    logic [SEL_W-1:0] idx;
    logic [7:0]       shreg;
    logic             timer_last, bit_last, last_ch;
`ifdef FRAME_HEADER_EN
    logic             hdr;
`endif

    assign timer_last = (timer == TW'(CLKS_PER_BIT - 1));
    assign bit_last   = (bit_idx == 3'd7);
    assign last_ch    = (idx == SEL_W'(NUM_CH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx         = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
`ifdef FRAME_HEADER_EN
                    state_next = START;
`else
                    state_next = SELECT;
`endif
                end
            end
            SELECT: state_next = START;
            START: begin
                tx = 1'b0;
                if (timer_last) state_next = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (timer_last && bit_last) state_next = STOP;
            end
            STOP: begin
                if (timer_last) begin
`ifdef FRAME_HEADER_EN
                    if (hdr) state_next = SELECT;
                    else
`endif
                    state_next = last_ch ? FINISH : SELECT;
                end
            end
            FINISH: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            bit_idx <= '0;
            idx     <= '0;
            sel     <= '0;
            shreg   <= '0;
`ifdef FRAME_HEADER_EN
            hdr     <= 1'b0;
`endif
        end else begin
            // Bit timer only runs while a bit is on the line
            if (state == START || state == DATA || state == STOP)
                timer <= timer_last ? '0 : timer + TW'(1);
            else
                timer <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        sel     <= '0;
                        bit_idx <= '0;
`ifdef FRAME_HEADER_EN
                        shreg   <= 8'hA5;
                        hdr     <= 1'b1;
`endif
                    end
                end
                SELECT: begin
                    shreg   <= send_data;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (timer_last) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (timer_last) begin
`ifdef FRAME_HEADER_EN
                        if (hdr) hdr <= 1'b0;
                        else
`endif
                        if (!last_ch) begin
                            idx <= idx + 1'b1;
                            sel <= idx + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    idx <= '0;
                    sel <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
